// File: rtl/acc_unit.sv
// Accumulator sequencer: accepts one instruction, drives an external ALU from
// registers, and writes the result back to the accumulator on the following edge.
module acc_unit #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [2:0]       In_Op,
    input  logic [WIDTH-1:0] In_Data,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [2:0]       ALU_OP,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic             ALU_Zero,
    output logic [WIDTH-1:0] Acc,
    output logic             Zero_Flag,
    output logic             Done,
    output logic [7:0]       Count,
    output logic             state_dbg
);

    // Handshake: an instruction transfers on a rising edge where In_Valid and
    // In_Ready are both high; In_Ready is high exactly while the FSM is IDLE.
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    state_t           state;
    logic [2:0]       op_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] operand_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            op_q      <= 3'b000;
            alu_op_q  <= 3'b000;
            operand_q <= '0;
            Acc       <= '0;
            Zero_Flag <= 1'b1;
            Done      <= 1'b0;
            Count     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (In_Valid) begin
                        op_q      <= In_Op;
                        // Non-ALU codes park the ALU on AND so its select stays legal.
                        alu_op_q  <= (In_Op > 3'b100) ? 3'b000 : In_Op;
                        operand_q <= In_Data;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_LOAD: begin
                            Acc       <= operand_q;
                            Zero_Flag <= (operand_q == '0);
                        end
                        OP_CLR: begin
                            Acc       <= '0;
                            Zero_Flag <= 1'b1;
                        end
                        OP_NOP: begin
                        end
                        default: begin
                            Acc       <= ALU_Out;
                            Zero_Flag <= ALU_Zero;
                        end
                    endcase
                    Done  <= 1'b1;
                    Count <= Count + 8'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign In_Ready  = (state == IDLE);
    assign ALU_A     = Acc;
    assign ALU_B     = operand_q;
    assign ALU_OP    = alu_op_q;
    assign state_dbg = state;

endmodule

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of the accumulator and all ALU-facing data ports.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 RSTn  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 In_Valid  input  1  SHALL flag that In_Op/In_Data hold an instruction.
REQ-005 In_Ready  output  1  SHALL flag that the block accepts an instruction this cycle.
REQ-006 In_Op  input  3  SHALL carry the instruction code (REQ-013).
REQ-007 In_Data  input  WIDTH  SHALL carry the instruction operand.
REQ-008 ALU_A  output  WIDTH  SHALL drive downstream ALU operand A.
REQ-009 ALU_B  output  WIDTH  SHALL drive downstream ALU operand B.
REQ-010 ALU_OP  output  3  SHALL drive downstream ALU op select (000 AND, 001 OR, 010 ADD, 011 SUB, 100 A<B).
REQ-011 ALU_Out  input  WIDTH  / ALU_Zero  input  1  SHALL return the combinational ALU result and its zero flag.
REQ-012 Acc  output  WIDTH; Zero_Flag  output  1; Done  output  1; Count  output  8  SHALL expose accumulator, registered zero flag, completion pulse, completed-instruction count.

Function
REQ-013 In_Op decode SHALL be: 000-100 ALU ops per REQ-010; 101 LOAD (Acc<=In_Data); 110 CLR (Acc<=0); 111 NOP (Acc unchanged).
REQ-014 FSM SHALL have two states, IDLE and EXEC; In_Ready SHALL equal (state==IDLE).
REQ-015 Handshake: instruction accepted on a rising edge where In_Valid=1 and In_Ready=1; In_Op/In_Data SHALL be latched into internal op/operand registers on that edge and state SHALL go IDLE->EXEC.
REQ-016 In_Valid while In_Ready=0 SHALL be ignored; inputs SHALL not be sampled outside the accept edge.
REQ-017 ALU_A SHALL be Acc, ALU_B the latched operand, ALU_OP the latched op (codes 101-111 drive ALU_OP=000); all three SHALL come from registers, no combinational path from In_*.
REQ-018 On the EXEC-cycle rising edge: ALU op -> Acc<=ALU_Out, Zero_Flag<=ALU_Zero; LOAD/CLR -> Acc<=new value, Zero_Flag<=(new value==0); NOP -> Acc, Zero_Flag unchanged; state SHALL return to IDLE.
REQ-019 Done SHALL be registered, high for exactly the one cycle following the EXEC edge, else low.
REQ-020 Count SHALL increment by 1 on each EXEC edge, all op codes incl. NOP, wrapping 255->0.
REQ-021 Latency: accept at edge k -> Acc/Zero_Flag/Count updated at edge k+1, Done high in cycle k+1..k+2, next accept earliest at edge k+2 (throughput one instruction per 2 cycles).
REQ-022 Arithmetic width/wrap SHALL be the ALU's (modulo 2^WIDTH); the block SHALL not detect overflow.
REQ-023 In_Valid held high continuously SHALL yield back-to-back accepts every second edge, each with inputs present at its accept edge.

Reset
REQ-024 RSTn=0 SHALL immediately force: state IDLE, Acc=0, Zero_Flag=1, Done=0, Count=0, latched op=000, latched operand=0 (so ALU_A=0, ALU_B=0, ALU_OP=000).
REQ-025 Reset asserted during EXEC SHALL abort the instruction: no Acc update, no Done pulse, no Count increment.
REQ-026 After RSTn deasserts, first accept SHALL be possible at the first rising edge with In_Valid=1.

Verification (bench connects alu16 as ALU)
REQ-027 Reset -> Acc=0, Zero_Flag=1, In_Ready=1, Done=0, Count=0, ALU_A=ALU_B=0.
REQ-028 LOAD 5; AND 1 -> Acc=1; OR 5 -> Acc=5; ADD 1 -> Acc=6; SUB 2 -> Acc=4; A<B with 5 -> Acc=1; Count=6, Done one cycle per instruction.
REQ-029 LOAD 5, SUB 5 -> Acc=0, Zero_Flag=1; LOAD 16'hFFFF, ADD 1 -> Acc=0, Zero_Flag=1; CLR -> Acc=0, Zero_Flag=1; NOP after LOAD 3 -> Acc=3, Count increments.
REQ-030 In_Valid held high with In_Data changing every cycle -> only values at accept edges (every 2nd edge) used; In_Ready low during EXEC.
REQ-031 LOAD 7 accepted, RSTn pulsed low during EXEC -> Acc=0, Done never high, Count=0, In_Ready=1 after release.
REQ-032 256 NOPs -> Count returns to 0; Acc unchanged throughout.
